// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Contents: ALU function-code localparams and the sequencer FSM state encoding.
// No logic; imported by alu_sequencer.
package alu_pkg;

   // ALU function codes driven on alu_sel
   localparam logic [2:0] SEL_ADD    = 3'b000;
   localparam logic [2:0] SEL_ASHL   = 3'b001;
   localparam logic [2:0] SEL_XNOR   = 3'b010;
   localparam logic [2:0] SEL_DIV2   = 3'b011;
   localparam logic [2:0] SEL_COMP2S = 3'b110;
   // 100, 101 and 111 all pass op1 through; this is the canonical one
   localparam logic [2:0] SEL_PASS   = 3'b100;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle command sequencer: iterates the external ALU N times, feeding alu_out back as op1.
// Latency: response valid N+1 cycles after the command handshake cycle; one command per N+2 cycles.
// Backpressure: cmd_ready low while EXEC/DONE; response held stable in DONE until rsp_ready.
// Ports: clk/rst_n; cmd_* valid/ready command in; alu_* to/from the ALU beside this block;
//        rsp_* valid/ready response out (data + sticky carry); busy high in EXEC or DONE.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_sel,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [CNT_W-1:0]  cmd_cnt,
   output logic [2:0]        alu_sel,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_co,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              busy
);

   seq_state_t        state, state_d;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] b_q;
   logic [2:0]        sel_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              carry_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (cmd_valid)                   state_d = ST_EXEC;
         ST_EXEC: if (cnt_q == CNT_W'(1))          state_d = ST_DONE;
         ST_DONE: if (rsp_ready)                   state_d = ST_IDLE;
         default:                                  state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch the command in IDLE, iterate the accumulator in EXEC.
   // Nothing changes in DONE, which keeps the response stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else if (state == ST_IDLE && cmd_valid) begin
         acc     <= cmd_a;
         b_q     <= cmd_b;
         sel_q   <= cmd_sel;
         // a zero count still runs one iteration
         cnt_q   <= (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
         carry_q <= 1'b0;
      end else if (state == ST_EXEC) begin
         acc     <= alu_out;
         carry_q <= carry_q | alu_co;
         cnt_q   <= cnt_q - CNT_W'(1);
      end
   end

   // Outputs come straight from registers/state. The ALU operands are the
   // command registers themselves, so outside EXEC they are stable and
   // deterministic (zero after reset) without extra output flops.
   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign alu_sel   = sel_q;
   assign alu_op1   = acc;
   assign alu_op2   = b_q;
   assign rsp_data  = acc;
   assign rsp_carry = carry_q;

endmodule
